// File: rtl/arb_req_collector.sv
// arb_req_collector
//   Collects one-cycle request pulses into per-port pending counters and
//   presents a request vector to a downstream fixed-priority arbiter. Grants
//   coming back from the arbiter retire pending requests. Also tracks how
//   long each pending port has waited (starvation) and flags lost requests
//   (overflow) and illegal grants (protocol error).
//
// Ports
//   clk         : clock, all flops rising-edge
//   reset       : synchronous, active-high reset
//   req_pulse_i : [N] request events, each set bit adds one pending request
//   gnt_i       : [N] grant from arbiter, expected one-hot or zero
//   req_o       : [N] port has pending requests (from registered counts)
//   ovf_o       : [N] sticky, a request was lost on a saturated counter
//   starve_o    : [N] port has waited STARVE_TH cycles without a grant
//   err_o       : sticky, an illegal grant was observed
module arb_req_collector #(
  parameter int N         = 32,
  parameter int CNT_W     = 4,
  parameter int STARVE_TH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_pulse_i,
  input  logic [N-1:0] gnt_i,
  output logic [N-1:0] req_o,
  output logic [N-1:0] ovf_o,
  output logic [N-1:0] starve_o,
  output logic         err_o
);

  localparam int AGE_W = $clog2(STARVE_TH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_TH);

  logic [CNT_W-1:0] cnt [N];
  logic [AGE_W-1:0] age [N];
  logic             gnt_onehot0;
  logic             gnt_illegal;
  logic [N-1:0]     vg;

  // Clearing the lowest set bit leaves zero only for one-hot or zero vectors.
  always_comb begin
    gnt_onehot0 = ((gnt_i & (gnt_i - N'(1))) == '0);
    vg          = gnt_onehot0 ? (gnt_i & req_o) : '0;
    gnt_illegal = !gnt_onehot0 || ((gnt_i & ~req_o) != '0);
  end

  always_comb begin
    req_o    = '0;
    starve_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      req_o[i]    = (cnt[i] != '0);
      starve_o[i] = (age[i] == AGE_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        cnt[i] <= '0;
        age[i] <= '0;
      end
      ovf_o <= '0;
      err_o <= 1'b0;
    end else begin
      if (gnt_illegal) err_o <= 1'b1;
      for (int unsigned i = 0; i < N; i++) begin
        // Pulse and valid grant together net to zero, so no overflow there.
        if (req_pulse_i[i] && !vg[i]) begin
          if (cnt[i] == CNT_MAX) ovf_o[i] <= 1'b1;
          else                   cnt[i]   <= cnt[i] + 1'b1;
        end else if (vg[i] && !req_pulse_i[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end

        if (!req_o[i] || vg[i])  age[i] <= '0;
        else if (age[i] != AGE_MAX) age[i] <= age[i] + 1'b1;
      end
    end
  end

endmodule

// File: doc/arb_req_collector.md
ARB_REQ_COLLECTOR -- requirements
Module: arb_req_collector

Interface
REQ-001 SHALL have parameter N, default 32, meaning number of requester ports.
REQ-002 SHALL have parameter CNT_W, default 4, meaning width of each per-port pending-request counter (max 2^CNT_W-1).
REQ-003 SHALL have parameter STARVE_TH, default 16, meaning cycles a pending port may wait ungranted before starve_o asserts (>=1).
REQ-004 SHALL have port clk  input  1  clock; one clock, all flops positive-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_pulse_i  input  N  one-cycle request events; each set bit adds one pending request to that port.
REQ-007 SHALL have port gnt_i  input  N  grant from the downstream fixed-priority arbiter; expected one-hot or zero.
REQ-008 SHALL have port req_o  output  N  request vector to the arbiter; bit i high when port i has pending requests.
REQ-009 SHALL have port ovf_o  output  N  sticky per-port overflow flag.
REQ-010 SHALL have port starve_o  output  N  per-port starvation indicator.
REQ-011 SHALL have port err_o  output  1  sticky protocol-error flag for illegal grants.

Function
REQ-012 SHALL keep per-port counter cnt[i] (CNT_W bits); req_o[i] = (cnt[i] != 0), driven from registered state only (no combinational path from req_pulse_i or gnt_i to req_o).
REQ-013 SHALL define valid grant vg[i] = gnt_i[i] & req_o[i] & onehot0(gnt_i); non-valid grant bits are ignored.
REQ-014 SHALL update cnt[i] each edge: +1 if req_pulse_i[i] & ~vg[i]; -1 if vg[i] & ~req_pulse_i[i]; unchanged if both or neither.
REQ-015 SHALL saturate cnt[i] at max; increment at max without vg[i] leaves cnt unchanged and sets ovf_o[i] next cycle (request lost).
REQ-016 SHALL NOT set ovf_o[i] when cnt[i]=max and req_pulse_i[i] & vg[i] coincide (net zero).
REQ-017 SHALL give latency: pulse at edge T visible on req_o at T+1; grant sampled at edge T reduces count from T+1.
REQ-018 SHALL keep per-port age counter age[i]: cleared when req_o[i]=0 or vg[i]=1, else +1 per cycle, saturating at STARVE_TH.
REQ-019 SHALL drive starve_o[i] = (age[i] == STARVE_TH), registered state only; it deasserts the cycle after a valid grant to port i.
REQ-020 SHALL set err_o next cycle when gnt_i has more than one bit set, or any gnt_i[i] with req_o[i]=0; counters are not changed by illegal bits.
REQ-021 SHALL hold ovf_o and err_o set until reset.
REQ-022 SHALL treat ports independently; activity on port j never alters cnt/age of port i != j.

Reset
REQ-023 SHALL on reset high at an edge clear all cnt, age, ovf_o, err_o; req_o and starve_o read 0 the following cycle.
REQ-024 SHALL give reset priority over simultaneous req_pulse_i/gnt_i in the same cycle; pending requests are discarded mid-operation.

Verification (N=4, CNT_W=2, STARVE_TH=4)
REQ-025 SHALL cover: req_pulse_i=0x3 at T, gnt_i=0 -> req_o=0x3 at T+1; gnt_i=0x1 at T+1 -> req_o=0x2 at T+2, err_o=0.
REQ-026 SHALL cover: 4 pulses on port0, no grant -> cnt0=3, ovf_o=0x1 after 4th edge; then 3 grants of 0x1 -> req_o[0]=0, ovf_o stays 0x1.
REQ-027 SHALL cover: cnt2=1, req_pulse_i=0x4 and gnt_i=0x4 same cycle -> cnt2=1, req_o=0x4 unchanged; at cnt2=3 same stimulus -> ovf_o[2]=0.
REQ-028 SHALL cover: port3 pending, gnt_i=0 -> starve_o=0x8 exactly 4 cycles after req_o[3] rises; gnt_i=0x8 -> starve_o=0 next cycle.
REQ-029 SHALL cover: req_o=0x0, gnt_i=0x4 -> err_o=1 next cycle, counts unchanged; separately req_o=0x3, gnt_i=0x3 -> err_o=1, req_o stays 0x3.
REQ-030 SHALL cover: counts {3,2,1,0}, ovf_o/err_o set, reset pulsed with req_pulse_i=0xF -> next cycle req_o, starve_o, ovf_o, err_o all 0.
